imem_arbiter: RTL and testbench

Two-port access arbiter that shares the single-port 2048x32 instruction BSRAM between the core's instruction-fetch port (read-only) and the loader/debug port (read/write). It sits between the core, the UART bootloader and the `bsram_imem8k` instance, and drives every BSRAM control pin. It holds the core in reset-fetch after power-up until the loader has finished programming. It also prevents a long loader burst from starving instruction fetch.

---
 rtl/imem_arb_pkg.sv | 20 ++
 rtl/imem_arbiter_rst_sync.sv | 22 ++
 rtl/imem_arbiter.sv | 119 +++++++++++
 tb/tb_imem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arbiter shared types: FSM state, response source tag, widths.
// Imported by the arbiter top.
package imem_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
  localparam int BURST_DEF  = 8;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_FETCH = 2'd1,
    SRC_LD    = 2'd2
  } src_e;

endpackage

// File: rtl/imem_arbiter_rst_sync.sv
// Async-assert / sync-deassert reset for the BSRAM.
// Output is high during rst_n low and for two edges after release.
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_out
);

  logic [1:0] sync_q;

  // Shift zeros in after release; both flops preset while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign rst_out = sync_q[1];

endmodule

// File: rtl/imem_arbiter.sv
// Fetch / loader arbiter in front of the single-port instruction BSRAM.
// IMEM_BOOT_HOLD_EN: hold fetch in BOOT until boot_done (else start in RUN).
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              boot_done,
  output logic              core_hold,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  output logic              mem_reset,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e     state;
  src_e       tag;
  logic [7:0] burst_cnt;
  logic       fetch_wins;

  rst_sync u_rst_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_out (mem_reset)
  );

`ifdef IMEM_BOOT_HOLD_EN
  // Leave BOOT on the first edge that sees boot_done; RUN is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else if (state == BOOT && boot_done) begin
      state <= RUN;
    end
  end

  assign core_hold = (state == BOOT);
`else
  logic unused_boot_done;

  assign unused_boot_done = boot_done;
  assign state            = RUN;
  assign core_hold        = 1'b0;
`endif

  assign fetch_wins = fetch_req && (burst_cnt == 8'(MAX_BURST));

  // Loader has priority unless it has starved a pending fetch too long.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (mem_reset) begin
      fetch_gnt = 1'b0;
    end else if (state == BOOT) begin
      ld_gnt = ld_req;
    end else if (fetch_wins) begin
      fetch_gnt = 1'b1;
    end else if (ld_req) begin
      ld_gnt = 1'b1;
    end else begin
      fetch_gnt = fetch_req;
    end
  end

  // Count loader grants that kept a pending fetch waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 8'd0;
    end else if (state != RUN || !fetch_req || fetch_gnt) begin
      burst_cnt <= 8'd0;
    end else if (ld_gnt) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // Remember who owns the read data coming out next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= SRC_NONE;
    end else if (fetch_gnt) begin
      tag <= SRC_FETCH;
    end else if (ld_gnt) begin
      tag <= SRC_LD;
    end else begin
      tag <= SRC_NONE;
    end
  end

  assign fetch_rvalid = (tag == SRC_FETCH);
  assign ld_rvalid    = (tag == SRC_LD);
  assign fetch_rdata  = mem_dout;
  assign ld_rdata     = mem_dout;

  assign mem_ce  = fetch_gnt | ld_gnt;
  assign mem_oce = 1'b1;
  assign mem_wre = ld_gnt & ld_we;
  assign mem_ad  = ld_gnt ? ld_addr : fetch_addr;
  assign mem_din = ld_gnt ? ld_wdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a behavioural BSRAM.
// Builds with or without IMEM_BOOT_HOLD_EN.
module tb_imem_arbiter;

`ifdef IMEM_BOOT_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  typedef struct {
    logic        is_ld;
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [10:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        ld_req, ld_we;
  logic [10:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        boot_done, core_hold;
  logic        mem_ce, mem_oce, mem_wre, mem_reset;
  logic [10:0] mem_ad;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] bram [0:2047];
  logic [31:0] ref_mem [0:2047];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) bram[mem_ad] <= mem_din;
      else mem_dout <= bram[mem_ad];
    end
  end

  imem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .boot_done    (boot_done),
    .core_hold    (core_hold),
    .mem_ce       (mem_ce),
    .mem_oce      (mem_oce),
    .mem_wre      (mem_wre),
    .mem_reset    (mem_reset),
    .mem_ad       (mem_ad),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // One cycle: record the grant, clock, then score the response.
  task automatic step();
    exp_t e;
    #1;
    n_checks++; if ((fetch_gnt & ld_gnt) !== 1'b0) begin n_fail++; $display("FAIL two_gnt: fgnt=%b lgnt=%b", fetch_gnt, ld_gnt); end
    n_checks++; if (mem_ce !== (fetch_gnt | ld_gnt)) begin n_fail++; $display("FAIL mem_ce: got %b want %b", mem_ce, fetch_gnt | ld_gnt); end
    n_checks++; if (mem_wre !== (ld_gnt & ld_we)) begin n_fail++; $display("FAIL mem_wre: got %b want %b", mem_wre, ld_gnt & ld_we); end
    if (ld_gnt === 1'b1) begin
      n_checks++; if (mem_ad !== ld_addr) begin n_fail++; $display("FAIL ld_ad: got %h want %h", mem_ad, ld_addr); end
      if (ld_we) begin
        ref_mem[ld_addr] = ld_wdata;
        e = '{1'b1, 1'b1, 32'h0};
      end else begin
        e = '{1'b1, 1'b0, ref_mem[ld_addr]};
      end
      sb.push_back(e);
    end else if (fetch_gnt === 1'b1) begin
      n_checks++; if (mem_ad !== fetch_addr) begin n_fail++; $display("FAIL fetch_ad: got %h want %h", mem_ad, fetch_addr); end
      e = '{1'b0, 1'b0, ref_mem[fetch_addr]};
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (ld_rvalid !== e.is_ld || fetch_rvalid !== !e.is_ld) begin
        n_fail++; $display("FAIL rvalid: got f=%b l=%b want ld=%b", fetch_rvalid, ld_rvalid, e.is_ld);
      end
      if (!e.is_wr) begin
        n_checks++;
        if ((e.is_ld ? ld_rdata : fetch_rdata) !== e.data) begin
          n_fail++; $display("FAIL rdata: got f=%h l=%h want %h", fetch_rdata, ld_rdata, e.data);
        end
      end
    end else begin
      n_checks++; if ({fetch_rvalid, ld_rvalid} !== 2'b00) begin n_fail++; $display("FAIL spurious_rvalid: got %b%b", fetch_rvalid, ld_rvalid); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_fgnt: got %b want 0", fetch_gnt); end
    n_checks++; if (ld_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_lgnt: got %b want 0", ld_gnt); end
    n_checks++; if ({fetch_rvalid, ld_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b%b", fetch_rvalid, ld_rvalid); end
    n_checks++; if ({mem_ce, mem_wre} !== 2'b00) begin n_fail++; $display("FAIL rst_ce_wre: got %b%b want 00", mem_ce, mem_wre); end
    n_checks++; if (mem_reset !== 1'b1) begin n_fail++; $display("FAIL rst_memrst: got %b want 1", mem_reset); end
    n_checks++; if (core_hold !== HOLD) begin n_fail++; $display("FAIL rst_hold: got %b want %b", core_hold, HOLD); end
    n_checks++; if (mem_oce !== 1'b1) begin n_fail++; $display("FAIL oce: got %b want 1", mem_oce); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (mem_reset !== 1'b1) begin n_fail++; $display("FAIL rel_edge1: got %b want 1", mem_reset); end
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL rel_fgnt1: got %b want 0", fetch_gnt); end
    @(posedge clk); #1;
    n_checks++; if (mem_reset !== 1'b0) begin n_fail++; $display("FAIL rel_edge2: got %b want 0", mem_reset); end
    n_checks++; if (fetch_gnt !== !HOLD) begin n_fail++; $display("FAIL first_fetch: got %b want %b", fetch_gnt, !HOLD); end
    @(negedge clk);
    step();
    fetch_req = 1'b0;
  endtask

`ifdef IMEM_BOOT_HOLD_EN
  task automatic test_boot();
    fetch_req = 1'b1; fetch_addr = 11'd5;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd5; ld_wdata = 32'h0000_0013;
    #1;
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL boot_fgnt: got %b want 0", fetch_gnt); end
    n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL boot_hold: got %b want 1", core_hold); end
    n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL boot_lgnt: got %b want 1", ld_gnt); end
    n_checks++; if (mem_ad !== 11'd5) begin n_fail++; $display("FAIL boot_ad: got %h want 005", mem_ad); end
    step();
    ld_req = 1'b0; ld_we = 1'b0; boot_done = 1'b1;
    #1;
    n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL boot_edge_fgnt: got %b want 0", fetch_gnt); end
    step();
    boot_done = 1'b0;
    #1;
    n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL run_hold: got %b want 0", core_hold); end
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL run_fgnt: got %b want 1", fetch_gnt); end
    step();
    fetch_req = 1'b0;
  endtask
`else
  task automatic test_run_direct();
    fetch_req = 1'b1; fetch_addr = 11'd5;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd5; ld_wdata = 32'h0000_0013;
    boot_done = 1'b0;
    #1;
    n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL nohold: got %b want 0", core_hold); end
    n_checks++; if (ld_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL ld_prio: got l=%b f=%b want l=1 f=0", ld_gnt, fetch_gnt); end
    step();
    ld_req = 1'b0; ld_we = 1'b0;
    #1;
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL run_fgnt: got %b want 1", fetch_gnt); end
    step();
    fetch_req = 1'b0;
  endtask
`endif

  task automatic test_fetch_stream();
    fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 11'(i); ld_wdata = $urandom;
      step();
    end
    ld_addr = 11'h7ff; ld_wdata = 32'hDEAD_BEEF;
    step();
    ld_req = 1'b0; ld_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = 11'(i);
      #1;
      n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL stream_gnt%0d: got %b want 1", i, fetch_gnt); end
      step();
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_ld_read();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd2;
    #1;
    n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL ldrd_gnt: got %b want 1", ld_gnt); end
    step();
    ld_addr = 11'h7ff;
    step();
    ld_req = 1'b0;
    step();
  endtask

  task automatic test_burst();
    int run = 0;
    int max_run = 0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd1;
    fetch_req = 1'b1; fetch_addr = 11'd3;
    for (int i = 0; i < 27; i++) begin
      #1;
      n_checks++;
      if (fetch_gnt !== ((i % 9) == 8) || ld_gnt !== ((i % 9) != 8)) begin
        n_fail++; $display("FAIL burst%0d: got f=%b l=%b want f=%b", i, fetch_gnt, ld_gnt, (i % 9) == 8);
      end
      run = (ld_gnt === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      step();
    end
    n_checks++; if (max_run > 8) begin n_fail++; $display("FAIL burst_max: got %0d want <=8", max_run); end
  endtask

  task automatic test_burst_clear();
    for (int j = 0; j < 15; j++) begin
      fetch_req = (j != 5);
      #1;
      n_checks++;
      if (fetch_gnt !== (j == 14) || ld_gnt !== (j != 14)) begin
        n_fail++; $display("FAIL bclr%0d: got f=%b l=%b want f=%b", j, fetch_gnt, ld_gnt, j == 14);
      end
      step();
    end
    ld_req = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd2; fetch_req = 1'b1; fetch_addr = 11'd0;
    #1;
    n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b want 1", ld_gnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({fetch_gnt, ld_gnt, mem_ce, mem_wre} !== 4'b0000) begin n_fail++; $display("FAIL mid_outs: got %b want 0000", {fetch_gnt, ld_gnt, mem_ce, mem_wre}); end
    n_checks++; if (mem_reset !== 1'b1) begin n_fail++; $display("FAIL mid_memrst: got %b want 1", mem_reset); end
    n_checks++; if (core_hold !== HOLD) begin n_fail++; $display("FAIL mid_hold: got %b want %b", core_hold, HOLD); end
    @(posedge clk); #1;
    n_checks++; if ({fetch_rvalid, ld_rvalid} !== 2'b00) begin n_fail++; $display("FAIL mid_rvalid: got %b%b want 00", fetch_rvalid, ld_rvalid); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (mem_reset !== 1'b1) begin n_fail++; $display("FAIL mid_edge1: got %b want 1", mem_reset); end
    n_checks++; if ({ld_gnt, ld_rvalid, fetch_gnt} !== 3'b000) begin n_fail++; $display("FAIL mid_sync: got %b want 000", {ld_gnt, ld_rvalid, fetch_gnt}); end
    @(posedge clk); #1;
    n_checks++; if (mem_reset !== 1'b0) begin n_fail++; $display("FAIL mid_edge2: got %b want 0", mem_reset); end
    n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_regnt: got %b want 1", ld_gnt); end
    @(negedge clk);
    step();
    ld_req = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; boot_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 11'd0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 11'd0; ld_wdata = 32'd0;
    test_reset();
`ifdef IMEM_BOOT_HOLD_EN
    test_boot();
`else
    test_run_direct();
`endif
    test_fetch_stream();
    test_ld_read();
    test_burst();
    test_burst_clear();
    test_reset_mid();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_left: got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
